// File: rtl/p_hardisc.sv
// Shared constants and types for the hardisc prediction structures.
// Pure declarations: no logic, no latency, no flow control.
package p_hardisc;

    localparam int BOP_WIDTH     = 32;
    localparam int BOP_MAX_DEPTH = 16;

    // Sized for the largest legal ring so every instance can share one type.
    typedef logic [$clog2(BOP_MAX_DEPTH)-1:0] bop_ring_ptr;

endpackage

// File: rtl/seu_regs.sv
// Bank of N write-enabled W-bit registers, optionally async-reset, tagged LABEL/GROUP.
// One-cycle write latency; writes are never refused.
module seu_regs #(
    parameter string LABEL = "REGS",
    parameter int    GROUP = 1,
    parameter int    N     = 1,
    parameter int    W     = 1,
    parameter bit    RST   = 1'b1
) (
    input  logic                s_clk_i,
    input  logic                s_resetn_i,
    input  logic [N-1:0]        s_we_i,
    input  logic [N-1:0][W-1:0] s_d_i,
    output logic [N-1:0][W-1:0] s_q_o
);

    if (N < 1 || W < 1 || GROUP < 1) begin : g_bad_cfg
        $error("seu_regs %s: illegal N/W/GROUP", LABEL);
    end

    if (RST) begin : g_rst
        always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
            if (!s_resetn_i) begin
                s_q_o <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (s_we_i[i]) s_q_o[i] <= s_d_i[i];
                end
            end
        end
    end else begin : g_norst
        logic unused_rst;
        assign unused_rst = s_resetn_i;

        always_ff @(posedge s_clk_i) begin
            for (int i = 0; i < N; i++) begin
                if (s_we_i[i]) s_q_o[i] <= s_d_i[i];
            end
        end
    end

endmodule

// File: rtl/bop_ring.sv
// Circular prediction buffer; head visible one cycle after push, no bypass. Full drops pushes
// (s_ovf_o), empty ignores pops (s_unf_o). Optional head parity check under BOP_PARITY_EN.
module bop_ring
    import p_hardisc::*;
#(
    parameter int    WIDTH      = BOP_WIDTH,
    parameter int    DEPTH      = 4,
    parameter int    AFULL_FREE = 1,
    parameter string LABEL      = "BOPR"
) (
    input  logic                       s_clk_i,
    input  logic                       s_resetn_i,
    input  logic                       s_flush_i,
    input  logic                       s_push_i,
    input  logic                       s_pop_i,
    input  logic [WIDTH-1:0]           s_data_i,
    output logic [WIDTH-1:0]           s_data_o,
    output logic                       s_entry_ready_o,
    output logic                       s_full_o,
    output logic                       s_afull_o,
    output logic [$clog2(DEPTH+1)-1:0] s_count_o,
    output logic                       s_ovf_o,
    output logic                       s_unf_o
`ifdef BOP_PARITY_EN
    ,
    output logic                       s_perr_o
`endif
);

    localparam int CW = $clog2(DEPTH+1);
`ifdef BOP_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    typedef struct packed {
        bop_ring_ptr   wptr;
        bop_ring_ptr   rptr;
        logic [CW-1:0] cnt;
    } ring_state_t;

    ring_state_t               st_q, st_d;
    logic [DEPTH-1:0]          data_we;
    logic [DEPTH-1:0][SW-1:0]  data_d, data_q;
    logic [SW-1:0]             entry_in, head;
    logic                      full, empty, push_ok, pop_ok;

    assign full    = (st_q.cnt == CW'(DEPTH));
    assign empty   = (st_q.cnt == '0);
    assign push_ok = s_push_i && (!full || s_pop_i);
    assign pop_ok  = s_pop_i && !empty;

`ifdef BOP_PARITY_EN
    assign entry_in = {^s_data_i, s_data_i};
`else
    assign entry_in = s_data_i;
`endif

    always_comb begin
        data_we = '0;
        data_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = entry_in;
            data_we[i] = push_ok && !s_flush_i && (st_q.wptr == bop_ring_ptr'(i));
        end
    end

    always_comb begin
        st_d = st_q;
        if (s_flush_i) begin
            st_d = '0;
        end else begin
            if (push_ok) st_d.wptr = (st_q.wptr == bop_ring_ptr'(DEPTH-1)) ? '0 : st_q.wptr + 1'b1;
            if (pop_ok)  st_d.rptr = (st_q.rptr == bop_ring_ptr'(DEPTH-1)) ? '0 : st_q.rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   st_d.cnt = st_q.cnt + 1'b1;
                2'b01:   st_d.cnt = st_q.cnt - 1'b1;
                default: st_d.cnt = st_q.cnt;
            endcase
        end
    end

    seu_regs #(
        .LABEL (LABEL),
        .GROUP (5),
        .N     (DEPTH),
        .W     (SW),
        .RST   (1'b0)
    ) u_data (
        .s_clk_i    (s_clk_i),
        .s_resetn_i (s_resetn_i),
        .s_we_i     (data_we),
        .s_d_i      (data_d),
        .s_q_o      (data_q)
    );

    seu_regs #(
        .LABEL ({LABEL, "PTR"}),
        .GROUP (5),
        .N     (1),
        .W     ($bits(ring_state_t)),
        .RST   (1'b1)
    ) u_ptr (
        .s_clk_i    (s_clk_i),
        .s_resetn_i (s_resetn_i),
        .s_we_i     (1'b1),
        .s_d_i      (st_d),
        .s_q_o      (st_q)
    );

    // Pointer type is wider than the entry index, so select by compare instead of indexing.
    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q.rptr == bop_ring_ptr'(i)) head = data_q[i];
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            s_ovf_o <= 1'b0;
            s_unf_o <= 1'b0;
        end else begin
            s_ovf_o <= !s_flush_i && s_push_i && full && !s_pop_i;
            s_unf_o <= !s_flush_i && s_pop_i && empty;
        end
    end

    assign s_data_o        = head[WIDTH-1:0];
    assign s_count_o       = st_q.cnt;
    assign s_entry_ready_o = !empty;
    assign s_full_o        = full;
    assign s_afull_o       = (st_q.cnt == CW'(DEPTH - AFULL_FREE));

`ifdef BOP_PARITY_EN
    assign s_perr_o = !empty && ((^head[WIDTH-1:0]) != head[WIDTH]);
`endif

endmodule

// File: tb/tb_bop_ring.sv
// Directed self-checking bench for bop_ring with DEPTH=3, WIDTH=8.
module tb_bop_ring;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, push, pop;
    logic [7:0] din;
    logic [7:0] dout;
    logic       ready, full, afull, ovf, unf;
    logic [1:0] count;
`ifdef BOP_PARITY_EN
    logic       perr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bop_ring #(
        .WIDTH      (8),
        .DEPTH      (3),
        .AFULL_FREE (1),
        .LABEL      ("TBR")
    ) dut (
        .s_clk_i         (clk),
        .s_resetn_i      (rst_n),
        .s_flush_i       (flush),
        .s_push_i        (push),
        .s_pop_i         (pop),
        .s_data_i        (din),
        .s_data_o        (dout),
        .s_entry_ready_o (ready),
        .s_full_o        (full),
        .s_afull_o       (afull),
        .s_count_o       (count),
        .s_ovf_o         (ovf),
        .s_unf_o         (unf)
`ifdef BOP_PARITY_EN
        ,
        .s_perr_o        (perr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge for sampling.
    task automatic step(input logic f, input logic pu, input logic po, input logic [7:0] d);
        flush = f;
        push  = pu;
        pop   = po;
        din   = d;
        @(posedge clk);
        #1;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = 8'h00;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_full",  32'(full),  0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_ovf",   32'(ovf),   0);
        chk("rst_unf",   32'(unf),   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill: A, B, C
        step(0, 1, 0, 8'h0A);
        chk("fill1_count", 32'(count), 1);
        chk("fill1_ready", 32'(ready), 1);
        chk("fill1_afull", 32'(afull), 0);
        chk("fill1_data",  32'(dout),  32'h0A);
        step(0, 1, 0, 8'h0B);
        chk("fill2_count", 32'(count), 2);
        chk("fill2_afull", 32'(afull), 1);
        chk("fill2_full",  32'(full),  0);
        step(0, 1, 0, 8'h0C);
        chk("fill3_count", 32'(count), 3);
        chk("fill3_full",  32'(full),  1);
        chk("fill3_afull", 32'(afull), 0);
        chk("fill3_data",  32'(dout),  32'h0A);

        // Overflow: D dropped
        step(0, 1, 0, 8'h0D);
        chk("ovf_pulse", 32'(ovf),   1);
        chk("ovf_count", 32'(count), 3);
        chk("ovf_data",  32'(dout),  32'h0A);
        step(0, 0, 0, 8'h00);
        chk("ovf_clear", 32'(ovf),   0);

        // Drain in order
        step(0, 0, 1, 8'h00);
        chk("pop1_data",  32'(dout),  32'h0B);
        chk("pop1_count", 32'(count), 2);
        step(0, 0, 1, 8'h00);
        chk("pop2_data",  32'(dout),  32'h0C);
        chk("pop2_count", 32'(count), 1);
        step(0, 0, 1, 8'h00);
        chk("pop3_count", 32'(count), 0);
        chk("pop3_ready", 32'(ready), 0);
        chk("pop3_unf",   32'(unf),   0);

        // Streaming through pointer wrap at constant occupancy
        step(0, 1, 0, 8'h10);
        step(0, 1, 0, 8'h11);
        chk("wrap_pre_count", 32'(count), 2);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1, 8'(8'h12 + i));
            chk("wrap_data",  32'(dout),  32'(8'h11 + i));
            chk("wrap_count", 32'(count), 2);
        end
        step(0, 0, 1, 8'h00);
        chk("wrap_tail_data", 32'(dout), 32'h1B);
        step(0, 0, 1, 8'h00);
        chk("wrap_empty", 32'(count), 0);

        // Pop with push on empty
        step(0, 1, 1, 8'h05);
        chk("unf_pulse", 32'(unf),   1);
        chk("unf_count", 32'(count), 1);
        chk("unf_data",  32'(dout),  32'h05);
        chk("unf_ovf",   32'(ovf),   0);
        step(0, 0, 0, 8'h00);
        chk("unf_clear", 32'(unf),   0);

        // Flush beats push and pop
        step(0, 1, 0, 8'h06);
        chk("flush_pre_count", 32'(count), 2);
        step(1, 1, 1, 8'h07);
        chk("flush_count", 32'(count), 0);
        chk("flush_ready", 32'(ready), 0);
        chk("flush_ovf",   32'(ovf),   0);
        chk("flush_unf",   32'(unf),   0);

        // Async reset mid-burst with an overflow pulse live
        step(0, 1, 0, 8'h07);
        step(0, 1, 0, 8'h08);
        step(0, 1, 0, 8'h09);
        chk("burst_full", 32'(full), 1);
        push = 1'b1;
        din  = 8'h0A;
        @(posedge clk);
        #1;
        chk("burst_ovf", 32'(ovf), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_full",  32'(full),  0);
        chk("arst_ready", 32'(ready), 0);
        chk("arst_ovf",   32'(ovf),   0);
        chk("arst_afull", 32'(afull), 0);
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 1, 0, 8'h03);
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_data",  32'(dout),  32'h03);

`ifdef BOP_PARITY_EN
        chk("perr_clean", 32'(perr), 0);
        force dut.u_data.s_q_o[0][0] = 1'b0;
        #1;
        chk("perr_flip", 32'(perr), 1);
        release dut.u_data.s_q_o[0][0];
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bop_ring.md
BOP_RING -- requirements
Module: bop_ring

Interface
REQ-001 Parameter WIDTH, default BOP_WIDTH, bit width of one stored prediction.
REQ-002 Parameter DEPTH, default 4, number of entries; legal range 2..16, non-power-of-two allowed.
REQ-003 Parameter AFULL_FREE, default 1, free-entry count at which almost-full asserts; legal range 1..DEPTH-1.
REQ-004 Parameter LABEL, default "BOPR", label passed to the storage sub-module.
REQ-005 s_clk_i  input  1  clock, rising edge; the block has one clock.
REQ-006 s_resetn_i  input  1  reset, asynchronous, active-low.
REQ-007 s_flush_i  input  1  discard all entries.
REQ-008 s_push_i  input  1  write s_data_i into the tail entry.
REQ-009 s_pop_i  input  1  release the head entry.
REQ-010 s_data_i  input  WIDTH  prediction to push.
REQ-011 s_data_o  output  WIDTH  head entry, valid when s_entry_ready_o is 1.
REQ-012 s_entry_ready_o  output  1  at least one entry is occupied.
REQ-013 s_full_o  output  1  count equals DEPTH.
REQ-014 s_afull_o  output  1  DEPTH minus count equals AFULL_FREE.
REQ-015 s_count_o  output  $clog2(DEPTH+1)  occupied entries.
REQ-016 s_ovf_o  output  1  one-cycle pulse: a push was dropped.
REQ-017 s_unf_o  output  1  one-cycle pulse: a pop was ignored.

Function
REQ-018 Storage is a circular buffer with read and write pointers; each pointer wraps from DEPTH-1 to 0.
REQ-019 Push accepted: the write pointer's entry takes s_data_i at the clock edge; the write pointer advances; count increments.
REQ-020 Data pushed at edge N appears on s_data_o after edge N when the buffer was empty; there is no bypass in the same cycle.
REQ-021 s_data_o is driven combinationally from the entry at the read pointer.
REQ-022 Pop accepted: the read pointer advances and count decrements; the storage content is not cleared.
REQ-023 Push while full with no pop: data is dropped, state is unchanged, and s_ovf_o pulses in the next cycle.
REQ-024 Push and pop while full: both are accepted and count stays at DEPTH.
REQ-025 Pop while empty: ignored, s_unf_o pulses in the next cycle; with a simultaneous push, the push is accepted and count becomes 1.
REQ-026 Push and pop while not empty and not full: both are accepted and count is unchanged.
REQ-027 s_flush_i has priority over push and pop in the same cycle: both pointers and count go to 0, and s_ovf_o/s_unf_o are not raised.
REQ-028 All status outputs (s_entry_ready_o, s_full_o, s_afull_o, s_count_o) derive from registered count only.

Reset
REQ-029 While s_resetn_i is low, pointers and count are 0, and s_entry_ready_o, s_full_o, s_afull_o, s_ovf_o and s_unf_o are 0.
REQ-030 Storage entries are not reset; s_data_o is don't-care until the first push.
REQ-031 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Configuration
REQ-032 Macro BOP_PARITY_EN: when defined, each entry stores an extra even-parity bit computed over s_data_i at push.
REQ-033 With BOP_PARITY_EN defined, output s_perr_o (1 bit) equals 1 when s_entry_ready_o is 1 and the recomputed parity of the head entry mismatches its stored parity.
REQ-034 Without BOP_PARITY_EN, s_perr_o and the parity storage are absent.

Structure
REQ-035 The WIDTH default constant BOP_WIDTH and a bop_ring_ptr typedef sized $clog2(DEPTH) belong in p_hardisc.
REQ-036 Data storage uses the existing seu_regs sub-module (N=DEPTH, GROUP 5), labelled LABEL.
REQ-037 The pointers and count use a second seu_regs instance, labelled LABEL+"PTR".
REQ-038 No other sub-module is instantiated.

Verification
REQ-039 DEPTH=3: push 0xA, 0xB, 0xC in consecutive cycles -> count 1,2,3; s_afull_o=1 at count 2; s_full_o=1 at count 3; s_data_o=0xA.
REQ-040 Full with DEPTH=3: push 0xD, no pop -> s_ovf_o=1 for one cycle; then pop three times -> 0xA, 0xB, 0xC in order, and 0xD never appears.
REQ-041 DEPTH=3: run 10 pushes with simultaneous pops through pointer wrap -> output order equals input order and count stays constant.
REQ-042 Empty: pop with simultaneous push of 0x5 -> s_unf_o pulses, count=1, s_data_o=0x5.
REQ-043 Count=2 with push, pop and flush all asserted -> count=0 next cycle and no ovf/unf pulse; async reset mid-burst -> outputs are 0 before the next clock edge.
REQ-044 With BOP_PARITY_EN: flip one stored bit of the head entry -> s_perr_o=1; the same test without the macro compiles and the port is absent.
